// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and defaults for the counter and the downstream Gray_to_Binary decoder.
// Functions work on 32-bit vectors; callers zero-extend narrower values and truncate the result.
package gray_pkg;

  localparam int GRAY_DEFAULT_WIDTH = 4;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_counter_if.sv
// Control and output bundle of gray_counter; master drives controls, slave is the counter.
// No handshake: every control is sampled each clock, outputs are registered.
interface gray_counter_if #(
  parameter int WIDTH = gray_pkg::GRAY_DEFAULT_WIDTH
);
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_bin;
  logic             en;
  logic             up;
  logic [WIDTH-1:0] gray_out;
  logic             tc;
  logic             sat;

  modport master (
    output clr, load, load_bin, en, up,
    input  gray_out, tc, sat
  );

  modport slave (
    input  clr, load, load_bin, en, up,
    output gray_out, tc, sat
  );
endinterface

// File: rtl/bin2gray_enc.sv
// Combinational binary-to-Gray encoder (WIDTH up to 32); zero latency, no backpressure.
module bin2gray_enc
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  assign gray_o = WIDTH'(bin2gray(32'(bin_i)));

endmodule

// File: rtl/gray_counter.sv
// Registered Gray up/down counter with clear/load/enable; 1-cycle latency, no backpressure.
// Define GRAY_CNT_SATURATE_EN to hold at the limits instead of wrapping (sat output active).
module gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_DEFAULT_WIDTH
) (
  input logic          clk,
  input logic          rst_n,
  gray_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] limit;

`ifdef GRAY_CNT_SATURATE_EN
  logic sat_q, sat_d;
`endif

  always_comb begin
    bin_d    = bin_q;
    tc_d     = 1'b0;
    step_val = bus.up ? (bin_q + WIDTH'(1)) : (bin_q - WIDTH'(1));
    limit    = bus.up ? ALL_ONES : '0;
`ifdef GRAY_CNT_SATURATE_EN
    sat_d    = sat_q;
`endif
    if (bus.clr) begin
      bin_d = '0;
`ifdef GRAY_CNT_SATURATE_EN
      sat_d = 1'b0;
`endif
    end else if (bus.load) begin
      bin_d = bus.load_bin;
`ifdef GRAY_CNT_SATURATE_EN
      sat_d = 1'b0;
`endif
    end else if (bus.en) begin
`ifdef GRAY_CNT_SATURATE_EN
      // tc only on the step that arrives at the limit; a step pushing into it just holds
      bin_d = (bin_q == limit) ? bin_q : step_val;
      tc_d  = (bin_d == limit) && (bin_q != limit);
      sat_d = (bin_d == limit);
`else
      bin_d = step_val;
      tc_d  = (bin_q == limit);
`endif
    end
  end

  bin2gray_enc #(.WIDTH(WIDTH)) u_enc (
    .bin_i  (bin_d),
    .gray_o (gray_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      tc_q   <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      tc_q   <= tc_d;
    end
  end

`ifdef GRAY_CNT_SATURATE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign bus.sat = sat_q;
`else
  assign bus.sat = 1'b0;
`endif

  assign bus.gray_out = gray_q;
  assign bus.tc       = tc_q;

endmodule

// File: tb/tb_gray_counter.sv
// Directed bench for gray_counter (WIDTH=4); covers wrap or saturate depending on GRAY_CNT_SATURATE_EN.
module tb_gray_counter;
  import gray_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  logic [3:0] prev_gray;
  logic [3:0] up_seq [5];

  gray_counter_if #(.WIDTH(4)) bus ();

  gray_counter #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic t, input logic s);
    chk({tag, ".gray"}, 32'(bus.gray_out), 32'(g));
    chk({tag, ".tc"},   32'(bus.tc),       32'(t));
    chk({tag, ".sat"},  32'(bus.sat),      32'(s));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic l, input logic [3:0] lb, input logic e, input logic u);
    bus.clr      = c;
    bus.load     = l;
    bus.load_bin = lb;
    bus.en       = e;
    bus.up       = u;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    up_seq[0] = 4'b0001; up_seq[1] = 4'b0011; up_seq[2] = 4'b0010;
    up_seq[3] = 4'b0110; up_seq[4] = 4'b0111;

    // Reset, then idle
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    #12;
    chk_out("reset", 4'b0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("idle", 4'b0000, 1'b0, 1'b0);
    end

    // Count up 5 with decode and single-bit-change checks
    prev_gray = 4'b0000;
    drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out("up5", up_seq[i], 1'b0, 1'b0);
      chk("up5.decode", gray2bin(32'(bus.gray_out)), 32'(i + 1));
      chk("up5.hamming", 32'($countones(bus.gray_out ^ prev_gray)), 32'd1);
      prev_gray = bus.gray_out;
    end

    // Load beats enable; clear beats load
    drive(1'b0, 1'b1, 4'b1010, 1'b1, 1'b1);
    step();
    chk_out("load_over_en", 4'b1111, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 4'b1010, 1'b1, 1'b1);
    step();
    chk_out("clr_over_load", 4'b0000, 1'b0, 1'b0);

`ifndef GRAY_CNT_SATURATE_EN
    // Wrap down from 0, then continue
    drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    step();
    chk_out("wrap_down", 4'b1000, 1'b1, 1'b0);
    step();
    chk_out("after_wrap_down", 4'b1001, 1'b0, 1'b0);

    // Wrap up from all-ones
    drive(1'b0, 1'b1, 4'b1111, 1'b0, 1'b1);
    step();
    chk_out("load_ones", 4'b1000, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    step();
    chk_out("wrap_up", 4'b0000, 1'b1, 1'b0);
    step();
    chk_out("after_wrap_up", 4'b0001, 1'b0, 1'b0);

    // Direction toggling at the boundary gives back-to-back tc
    drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    step();
    chk_out("down_to_0", 4'b0000, 1'b0, 1'b0);
    step();
    chk_out("toggle_wrap_down", 4'b1000, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    step();
    chk_out("toggle_wrap_up", 4'b0000, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    step();
    chk_out("idle_after_wrap", 4'b0000, 1'b0, 1'b0);
`else
    // Down-step at 0 holds and saturates without tc
    drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    step();
    chk_out("sat_low", 4'b0000, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    step();
    chk_out("leave_low", 4'b0001, 1'b0, 1'b0);

    // Load a limit: no sat until steps push into it, never tc
    drive(1'b0, 1'b1, 4'b1111, 1'b0, 1'b1);
    step();
    chk_out("load_ones", 4'b1000, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("sat_hold", 4'b1000, 1'b0, 1'b1);
    end
    drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    step();
    chk_out("leave_high", 4'b1001, 1'b0, 1'b0);

    // Counting onto the limit pulses tc once
    drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    step();
    chk_out("reach_high", 4'b1000, 1'b1, 1'b1);
    step();
    chk_out("push_high", 4'b1000, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    step();
    chk_out("idle_sat", 4'b1000, 1'b0, 1'b1);
`endif

    // Asynchronous reset in the middle of an up-count
    drive(1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
    step();
    chk_out("clr", 4'b0000, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    step();
    step();
    chk_out("pre_arst", 4'b0011, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("arst_now", 4'b0000, 1'b0, 1'b0);
    step();
    chk_out("arst_held", 4'b0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    chk_out("resume1", 4'b0001, 1'b0, 1'b0);
    step();
    chk_out("resume2", 4'b0011, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
